// File: rtl/signed_divider_pkg.sv
// Shared types and helpers for the fixed-point divider (and its multiplier sibling).
package signed_divider_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } state_t;

  // Apply a sign to an unsigned magnitude and clamp it into a signed field of
  // 'width' bits. Result is two's complement in the low 'width' bits.
  function automatic logic [63:0] saturate(input logic [63:0] mag,
                                           input logic        neg,
                                           input int          width);
    logic [63:0] lim;
    lim = 64'd1 << (width - 1);
    if (neg) saturate = (mag > lim) ? (~lim + 64'd1) : (~mag + 64'd1);
    else     saturate = (mag > lim - 64'd1) ? (lim - 64'd1) : mag;
  endfunction

endpackage

// File: rtl/signed_divider_if.sv
// Start/valid handshake bundle between a divider client and the divider.
interface signed_divider_if #(
  parameter int INBITS1 = 14,
  parameter int INBITS2 = 14,
  parameter int OUTBITS = 14
);
  logic                      start_i;
  logic signed [INBITS1-1:0] numerator_i;
  logic signed [INBITS2-1:0] denominator_i;
  logic                      ready_o;
  logic                      valid_o;
  logic signed [OUTBITS-1:0] quotient_o;
  logic                      div0_o;

  modport master (
    output start_i, numerator_i, denominator_i,
    input  ready_o, valid_o, quotient_o, div0_o
  );

  modport slave (
    input  start_i, numerator_i, denominator_i,
    output ready_o, valid_o, quotient_o, div0_o
  );
endinterface

// File: rtl/signed_divider.sv
// Iterative restoring divider on Q1.(W-1) fractions: q = trunc0(num*2^S/den),
// saturated to OUTBITS. One quotient bit per clock, fixed latency of D+1 clocks.
module signed_divider
  import signed_divider_pkg::*;
#(
  parameter int INBITS1 = 14,
  parameter int INBITS2 = 14,
  parameter int OUTBITS = 14
) (
  input  logic           clk_i,
  input  logic           rst_i,
  signed_divider_if.slave bus
);

  localparam int S  = OUTBITS + INBITS2 - INBITS1 - 1;
  localparam int D  = INBITS1 + S;
  localparam int RW = INBITS2 + 1;
  localparam int CW = $clog2(D + 1);

  state_t               state, state_nx;
  logic [D-1:0]         dividend, quot;
  logic [INBITS2-1:0]   divisor, rem;
  logic [CW-1:0]        cnt;
  logic                 neg, den_zero, num_zero;

  logic [INBITS1-1:0]   num_mag;
  logic [INBITS2-1:0]   den_mag;
  logic [RW-1:0]        shifted, diff;
  logic                 ge;
  logic [63:0]          sat_res;

  // Operand magnitudes; the most negative value maps to 2^(W-1), which still
  // fits because the magnitude is held unsigned.
  assign num_mag = bus.numerator_i[INBITS1-1]   ? -bus.numerator_i   : bus.numerator_i;
  assign den_mag = bus.denominator_i[INBITS2-1] ? -bus.denominator_i : bus.denominator_i;

  // One restoring step: remainder < divisor <= 2^(INBITS2-1), so the trial
  // difference fits RW signed bits and its sign bit says "did not fit".
  assign shifted = {rem, dividend[D-1]};
  assign diff    = shifted - {1'b0, divisor};
  assign ge      = ~diff[RW-1];

  // Final signed/saturated result; a zero divisor overrides the iteration result.
  assign sat_res = den_zero ? saturate(num_zero ? 64'd0 : '1, neg, OUTBITS)
                            : saturate(64'(quot), neg, OUTBITS);

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic: IDLE -> CALC on accept, CALC for D steps, FINISH for one.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start_i) state_nx = CALC;
      CALC:    if (cnt == CW'(D - 1)) state_nx = FINISH;
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    bus.ready_o = (state == IDLE);
  end

  // Datapath: operand capture, iteration, and registered result.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dividend       <= '0;
      divisor        <= '0;
      rem            <= '0;
      quot           <= '0;
      cnt            <= '0;
      neg            <= 1'b0;
      den_zero       <= 1'b0;
      num_zero       <= 1'b0;
      bus.valid_o    <= 1'b0;
      bus.quotient_o <= '0;
      bus.div0_o     <= 1'b0;
    end else begin
      bus.valid_o <= 1'b0;
      case (state)
        IDLE: if (bus.start_i) begin
          dividend <= D'(num_mag) << S;
          divisor  <= den_mag;
          rem      <= '0;
          quot     <= '0;
          cnt      <= '0;
          neg      <= bus.numerator_i[INBITS1-1] ^ bus.denominator_i[INBITS2-1];
          den_zero <= (bus.denominator_i == '0);
          num_zero <= (bus.numerator_i == '0);
        end
        CALC: begin
          rem      <= ge ? diff[INBITS2-1:0] : shifted[INBITS2-1:0];
          dividend <= dividend << 1;
          quot     <= {quot[D-2:0], ge};
          cnt      <= cnt + CW'(1);
        end
        FINISH: begin
          bus.quotient_o <= sat_res[OUTBITS-1:0];
          bus.div0_o     <= den_zero;
          bus.valid_o    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_signed_divider.sv
// Directed bench for signed_divider: scoreboard of model + literal expectations,
// checked by a single negedge monitor.
module tb_signed_divider;

  localparam int W    = 14;
  localparam int SH   = 13;          // OUTBITS+INBITS2-INBITS1-1
  localparam int MAXP = 8191;
  localparam int MAXN = -8192;
  localparam int LAT  = 28;

  logic clk = 1'b0;
  logic rst_i;
  always #5 clk = ~clk;

  signed_divider_if #(.INBITS1(W), .INBITS2(W), .OUTBITS(W)) bus ();

  signed_divider #(.INBITS1(W), .INBITS2(W), .OUTBITS(W)) dut (
    .clk_i (clk),
    .rst_i (rst_i),
    .bus   (bus.slave)
  );

  typedef struct {
    int mq; bit md;      // model expectation
    int lq; bit ld;      // hand-computed expectation
    int acc; bit b2b;    // accept cycle, accepted on a valid_o cycle
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0, fails = 0;
  bit   rst_flag = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain integer division truncates toward zero, then clamp.
  function automatic void model(input int n, input int d, output int q, output bit z);
    longint p;
    z = (d == 0);
    if (d == 0) q = (n > 0) ? MAXP : (n < 0) ? MAXN : 0;
    else begin
      p = (longint'(n) * (longint'(1) << SH)) / longint'(d);
      q = (p > MAXP) ? MAXP : (p < MAXN) ? MAXN : int'(p);
    end
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: the only process that compares.
  int last_q = 0, last_v = 0;
  bit last_d = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst_i) begin
      sb.delete();
      last_q = 0;
      last_d = 1'b0;
      if (rst_flag) begin
        chk("reset_ready", int'(bus.ready_o), 1);
        chk("reset_valid", int'(bus.valid_o), 0);
        chk("reset_quot",  int'(bus.quotient_o), 0);
        chk("reset_div0",  int'(bus.div0_o), 0);
      end
    end else if (bus.valid_o) begin
      chk("ready_on_valid", int'(bus.ready_o), 1);
      if (sb.size() == 0) chk("spurious_valid", 1, 0);
      else begin
        e = sb.pop_front();
        chk("model_pin",   e.mq, e.lq);
        chk("model_quot",  int'(bus.quotient_o), e.mq);
        chk("model_div0",  int'(bus.div0_o), int'(e.md));
        chk("literal_quot", int'(bus.quotient_o), e.lq);
        chk("literal_div0", int'(bus.div0_o), int'(e.ld));
        chk("latency", cyc - e.acc, LAT);
        if (e.b2b) chk("b2b_spacing", cyc - last_v, LAT + 1);
      end
      last_v = cyc;
      last_q = int'(bus.quotient_o);
      last_d = bus.div0_o;
    end else begin
      chk("ready_level", int'(bus.ready_o), (sb.size() == 0) ? 1 : 0);
      chk("hold_quot", int'(bus.quotient_o), last_q);
      chk("hold_div0", int'(bus.div0_o), int'(last_d));
      if (sb.size() > 0 && cyc - sb[0].acc > LAT + 12) begin
        chk("timeout", cyc - sb[0].acc, LAT);
        void'(sb.pop_front());
      end
    end
  end

  // Drive one request starting at a negedge; record it right after acceptance.
  task automatic send(input int n, input int d, input int lq, input bit ld, input bit b2b);
    exp_t e;
    int   i;
    i = 0;
    if (!b2b) while (!bus.ready_o && i < 200) begin @(negedge clk); i++; end
    bus.start_i       = 1'b1;
    bus.numerator_i   = W'(n);
    bus.denominator_i = W'(d);
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    model(n, d, e.mq, e.md);
    e.lq = lq; e.ld = ld; e.acc = cyc; e.b2b = b2b;
    sb.push_back(e);
  endtask

  task automatic wait_valid();
    int i;
    i = 0;
    @(negedge clk);
    while (!bus.valid_o && i < 60) begin @(negedge clk); i++; end
  endtask

  task automatic junk_start(input int n, input int d);
    @(negedge clk);
    bus.start_i       = 1'b1;
    bus.numerator_i   = W'(n);
    bus.denominator_i = W'(d);
    @(posedge clk); #1;
    bus.start_i = 1'b0;
  endtask

  localparam int NV = 15;
  int vn [NV] = '{ 2048, -2048, 1, -1, 3, 4096, -4096, -8192, -8192, 100, -5, 0, 1000, -8192, 1000};
  int vd [NV] = '{ 4096,  4096, 3,  3, -1, 2048,  2048, -8192,  8191,   0,  0, 0, 2000,    -1, -3000};
  int vq [NV] = '{ 4096, -4096, 2730, -2730, -8192, 8191, -8192, 8191, -8192, 8191, -8192, 0, 4096, 8191, -2730};
  bit vz [NV] = '{ 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0};

  initial begin
    rst_i = 1'b1; rst_flag = 1'b1;
    bus.start_i = 1'b0; bus.numerator_i = '0; bus.denominator_i = '0;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0; rst_flag = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      send(vn[i], vd[i], vq[i], vz[i], i > 0);
      if (i == 0) begin
        // starts while busy, 5 and 20 cycles after accept, must be ignored
        repeat (4) @(posedge clk);
        junk_start(-8000, 3);
        repeat (14) @(posedge clk);
        junk_start(5, 0);
      end
      wait_valid();
    end
    repeat (3) @(negedge clk);

    // abort in the middle of the iteration
    send(2048, 4096, 4096, 1'b0, 1'b0);
    repeat (9) @(posedge clk);
    #1 rst_i = 1'b1; rst_flag = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1 rst_i = 1'b0; rst_flag = 1'b0;
    repeat (40) @(negedge clk);

    send(-1, 3, -2730, 1'b0, 1'b0);
    wait_valid();
    repeat (50) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
